keccak_share_loader: RTL

- Front-end stage directly upstream of keccak_top (Keccak-f[200], d+1 Boolean shares).
- Accepts a 25-byte unmasked message byte-serially and splits each byte into d+1 shares using externally supplied fresh randomness.
- Assembles the 200*(d+1)-bit shared state, drives keccak_top's InData and active-high Reset, and waits for its Ready.
- Captures the shared result and hands it downstream over a valid/ready handshake.

---
 rtl/keccak_share_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/keccak_share_loader.sv
// keccak_share_loader: splits a 25-byte message into d+1 Boolean shares, runs keccak_top and hands the shared result downstream.
// Optional macro KECCAK_LOADER_TIMEOUT_EN adds a RUN watchdog and a Timeout pulse output.
module keccak_share_loader #(
    parameter int d = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [7:0]           InByte,
    input  logic [8*d-1:0]       InRand,
    input  logic                 InValid,
    output logic                 InReady,
    output logic [200*(d+1)-1:0] CoreInData,
    output logic                 CoreReset,
    input  logic                 CoreReady,
    input  logic [200*(d+1)-1:0] CoreOutData,
    output logic [200*(d+1)-1:0] OutShares,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic                 Busy
`ifdef KECCAK_LOADER_TIMEOUT_EN
    ,
    output logic                 Timeout
`endif
);
    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [4:0] cnt;
    logic       ready_prev;
    logic [7:0] share [d+1];
`ifdef KECCAK_LOADER_TIMEOUT_EN
    logic [7:0] wd;
`endif

    assign InReady = (state == LOAD);

    // The unmasked byte only meets the masks here, on the way into share d.
    always_comb begin
        share[d] = InByte;
        for (int j = 0; j < d; j++) begin
            share[j] = InRand[8*j +: 8];
            share[d] = share[d] ^ InRand[8*j +: 8];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= LOAD;
            cnt        <= '0;
            ready_prev <= 1'b0;
            CoreInData <= '0;
            CoreReset  <= 1'b1;
            OutShares  <= '0;
            OutValid   <= 1'b0;
            Busy       <= 1'b0;
`ifdef KECCAK_LOADER_TIMEOUT_EN
            wd         <= '0;
            Timeout    <= 1'b0;
`endif
        end else begin
            ready_prev <= CoreReady;
`ifdef KECCAK_LOADER_TIMEOUT_EN
            Timeout    <= 1'b0;
`endif
            case (state)
                LOAD: if (InValid) begin
                    for (int j = 0; j <= d; j++)
                        CoreInData[200*j + 8*int'(cnt) +: 8] <= share[j];
                    if (cnt == 5'd24) begin
                        cnt       <= '0;
                        state     <= RUN;
                        CoreReset <= 1'b0;
                        Busy      <= 1'b1;
`ifdef KECCAK_LOADER_TIMEOUT_EN
                        wd        <= '0;
`endif
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                RUN: if (CoreReady && !ready_prev) begin
                    OutShares <= CoreOutData;
                    OutValid  <= 1'b1;
                    CoreReset <= 1'b1;
                    Busy      <= 1'b0;
                    state     <= DONE;
                end
`ifdef KECCAK_LOADER_TIMEOUT_EN
                else if (wd == 8'd254) begin
                    CoreReset  <= 1'b1;
                    CoreInData <= '0;
                    Busy       <= 1'b0;
                    Timeout    <= 1'b1;
                    state      <= LOAD;
                end else begin
                    wd <= wd + 8'd1;
                end
`endif
                DONE: if (OutReady) begin
                    OutValid   <= 1'b0;
                    OutShares  <= '0;
                    CoreInData <= '0;
                    state      <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule
